// File: rtl/eea_pkg.sv
// Shared constants and types for the bit-level EEA inverter control.
// Consumed by eea_ctrl, eea_ctrl_decode and the D_Cell datapath.
package eea_pkg;

    localparam int M       = 163;
    localparam int DELTA_W = $clog2(2*M+1);
    localparam int CNT_W   = $clog2(2*M+1);

    // Field polynomial x^163 + x^7 + x^6 + x^3 + 1, R/S-aligned (M+1 bits).
    localparam logic [M:0] F = {1'b1, {(M-8){1'b0}}, 8'hC9};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } stateT;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INC,
        OP_DEC,
        OP_SET1
    } deltaOpT;

endpackage

// File: rtl/eea_ctrl_decode.sv
// Combinational D_Cell control decode: (run, rm, sm, delta==0) to
// Switch/Reduce/MultR and the delta update operation.
module eea_ctrl_decode
    import eea_pkg::*;
(
    input  logic    run,
    input  logic    rm,
    input  logic    sm,
    input  logic    deltaIsZero,
    output logic    Switch,
    output logic    Reduce,
    output logic    MultR,
    output deltaOpT deltaOp
);

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        Switch  = 1'b0;
        Reduce  = 1'b0;
        MultR   = 1'b0;
        deltaOp = OP_HOLD;
        if (run) begin
            if (!rm) begin
                MultR   = 1'b1;
                deltaOp = OP_INC;
            end else begin
                Reduce  = sm;
                Switch  = deltaIsZero;
                deltaOp = deltaIsZero ? OP_SET1 : OP_DEC;
            end
        end
    end

endmodule

// File: rtl/eea_ctrl.sv
// Sequencer for the 2M-iteration EEA inversion loop (IDLE/LOAD/RUN/DONE).
// Optional macro EEA_ZERO_CHK_EN: a zero operand skips RUN and flags err.
module eea_ctrl
    import eea_pkg::*;
#(
    parameter int M       = eea_pkg::M,
    parameter int DELTA_W = $clog2(2*M+1),
    parameter int CNT_W   = $clog2(2*M+1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic a_zero,
    input  logic rm,
    input  logic sm,
    output logic load,
    output logic step_en,
    output logic Switch,
    output logic Reduce,
    output logic MultR,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(2*M-1);
    localparam logic [DELTA_W-1:0] DELTA_MAX = DELTA_W'(2*M);

    stateT              state;
    stateT              stateNext;
    logic [DELTA_W-1:0] delta;
    logic [CNT_W-1:0]   cnt;
    logic               errFlag;
    logic               zeroSkip;
    logic               runPhase;
    deltaOpT            deltaOp;

`ifdef EEA_ZERO_CHK_EN
    assign zeroSkip = a_zero;
`else
    logic unusedAZero;
    assign unusedAZero = a_zero;
    assign zeroSkip    = 1'b0;
`endif

    assign runPhase = (state == RUN);

    eea_ctrl_decode uDecode (
        .run         (runPhase),
        .rm          (rm),
        .sm          (sm),
        .deltaIsZero (delta == '0),
        .Switch      (Switch),
        .Reduce      (Reduce),
        .MultR       (MultR),
        .deltaOp     (deltaOp)
    );

    // Handshake outputs depend on state only, never on rm/sm.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step_en   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: if (start) stateNext = LOAD;
            LOAD: begin
                load      = 1'b1;
                busy      = 1'b1;
                stateNext = zeroSkip ? DONE : RUN;
            end
            RUN: begin
                step_en = 1'b1;
                busy    = 1'b1;
                if (cnt == LAST_CNT) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                err       = errFlag;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!rst_n) begin
            state   <= IDLE;
            delta   <= '0;
            cnt     <= '0;
            errFlag <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: errFlag <= 1'b0;
                LOAD: begin
                    delta   <= '0;
                    cnt     <= '0;
                    errFlag <= zeroSkip;
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    case (deltaOp)
                        OP_INC:  delta <= delta + DELTA_W'(1);
                        OP_DEC:  delta <= delta - DELTA_W'(1);
                        OP_SET1: delta <= DELTA_W'(1);
                        default: delta <= delta;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // One increment per iteration at most, so delta stays within 2M.
    deltaBound: assert property (@(posedge clk) disable iff (!rst_n) delta <= DELTA_MAX);

endmodule
